// File: rtl/adder_pkg.sv
// Shared types and constants for the chunk-serial adder.
package adder_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Number of adder-slice passes needed for one operation.
  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational W-bit full adder slice; the only adder in the datapath.
module chunk_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  // Widen by one bit so the slice carry-out falls out of the sum.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per
// clock through one chunk_add slice, carry registered between chunks.
// Optional signed-overflow output enabled by ADDER_OVERFLOW_DETECT_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one chunk per clock, LSB chunk first
// DONE  | one-cycle done pulse, start ignored
module chunk_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVERFLOW_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $error("chunk_serial_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_t             state, state_next;
  logic               accept, last;
  logic [WIDTH-1:0]   op_a, op_b, work, work_next;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [CHUNK-1:0]   chunk_a, chunk_b, chunk_s;
  logic               chunk_co;

  assign chunk_a = op_a[idx*CHUNK +: CHUNK];
  assign chunk_b = op_b[idx*CHUNK +: CHUNK];

  chunk_add #(.W(CHUNK)) u_chunk_add (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .s    (chunk_s),
    .cout (chunk_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode plus accept/last-chunk strobes for the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          last       = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Working register with the current chunk merged in; on the last chunk
  // this is the complete result.
  always_comb begin
    work_next = work;
    work_next[idx*CHUNK +: CHUNK] = chunk_s;
  end

  // Operand capture, per-chunk accumulation and result/handshake registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      work  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= accept | ((state == RUN) & ~last);
      done <= last;
      if (accept) begin
        op_a  <= a;
        op_b  <= sub ? ~b : b;
        carry <= sub | cin;
        idx   <= '0;
      end else if (state == RUN) begin
        work  <= work_next;
        carry <= chunk_co;
        idx   <= idx + IDX_W'(1);
        if (last) begin
          sum  <= work_next;
          cout <= chunk_co;
        end
      end
    end
  end

`ifdef ADDER_OVERFLOW_DETECT_EN
  logic msb_cin;

  // Carry into the MSB recovered from the slice's top-bit sum.
  assign msb_cin = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_s[CHUNK-1];

  // Signed overflow flag, updated alongside sum.
  always_ff @(posedge clk) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (last) ovf <= msb_cin ^ chunk_co;
  end
`endif

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench for chunk_serial_adder: directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_chunk_serial_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin, sub;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef ADDER_OVERFLOW_DETECT_EN
  logic             ovf;
`endif

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] exp_sum;
  logic             exp_cout;
  logic             exp_ovf;

  chunk_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef ADDER_OVERFLOW_DETECT_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow from true signed range.
  function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                input logic mcin, input logic msub,
                                output logic [WIDTH-1:0] ms, output logic mc,
                                output logic mo);
    logic [WIDTH:0] full;
    longint sa, sb, r, lim;
    if (msub) begin
      ms = ma - mb;
      mc = (ma >= mb);
    end else begin
      full = {1'b0, ma} + {1'b0, mb} + {{WIDTH{1'b0}}, mcin};
      ms   = full[WIDTH-1:0];
      mc   = full[WIDTH];
    end
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    r   = msub ? (sa - sb) : (sa + sb + longint'(mcin));
    lim = longint'(1) <<< (WIDTH - 1);
    mo  = (r > lim - 1) || (r < -lim);
  endfunction

  task automatic check_result(input string tag);
    chk({tag, "_sum"}, {1'b0, sum}, {1'b0, exp_sum});
    chk({tag, "_cout"}, {{WIDTH{1'b0}}, cout}, {{WIDTH{1'b0}}, exp_cout});
`ifdef ADDER_OVERFLOW_DETECT_EN
    chk({tag, "_ovf"}, {{WIDTH{1'b0}}, ovf}, {{WIDTH{1'b0}}, exp_ovf});
`endif
  endtask

  // One complete operation; operands are scrambled after acceptance and
  // start optionally kept high to show both are ignored until IDLE again.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tcin, input logic tsub, input logic thold);
    logic [WIDTH-1:0] ns;
    logic nc, no;
    model(ta, tb_v, tcin, tsub, ns, nc, no);
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    chk("accept_busy", {{WIDTH{1'b0}}, busy}, {{WIDTH{1'b0}}, 1'b1});
    chk("accept_done", {{WIDTH{1'b0}}, done}, '0);
    for (int k = 1; k <= NCHUNK; k++) begin
      @(negedge clk);
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      cin = 1'($urandom); sub = 1'($urandom); start = thold;
      @(posedge clk); #1;
      if (k < NCHUNK) begin
        chk("run_busy", {{WIDTH{1'b0}}, busy}, {{WIDTH{1'b0}}, 1'b1});
        chk("run_done", {{WIDTH{1'b0}}, done}, '0);
        check_result("run_hold");
      end else begin
        exp_sum = ns; exp_cout = nc; exp_ovf = no;
        chk("fin_done", {{WIDTH{1'b0}}, done}, {{WIDTH{1'b0}}, 1'b1});
        chk("fin_busy", {{WIDTH{1'b0}}, busy}, '0);
        check_result("fin");
      end
    end
    @(posedge clk); #1;
    chk("post_done", {{WIDTH{1'b0}}, done}, '0);
    chk("post_busy", {{WIDTH{1'b0}}, busy}, '0);
    check_result("post");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {{WIDTH{1'b0}}, busy}, '0);
    chk("rst_done", {{WIDTH{1'b0}}, done}, '0);
    check_result("rst");
    @(negedge clk) rst_n = 1'b1;

    // Directed cases.
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b0);

    // Start held high: back-to-back accepts two cycles after each done.
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
    run_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b1, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // Idle with start low: nothing happens, result held.
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", {{WIDTH{1'b0}}, busy}, '0);
      chk("idle_done", {{WIDTH{1'b0}}, done}, '0);
    end
    check_result("idle");

    // Reset while chunk index 2 is pending.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    chk("abort_busy", {{WIDTH{1'b0}}, busy}, '0);
    chk("abort_done", {{WIDTH{1'b0}}, done}, '0);
    check_result("abort");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < NCHUNK + 3; i++) begin
      @(posedge clk); #1;
      chk("abort_nodone", {{WIDTH{1'b0}}, done}, '0);
    end
    run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net: the run is bounded by fixed cycle counts, this catches a stall.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
